// File: rtl/ahb_arbiter.sv
// AHB-lite multi-master arbiter: round-robin grant switched only on transfer/burst boundaries.
// Define AHB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (master 0 highest).
module ahb_arbiter #(
    parameter int mst_c  = 2,
    parameter int park_m = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [mst_c-1:0][31:0] haddr_m,
    input  logic [mst_c-1:0][31:0] hwdata_m,
    input  logic [mst_c-1:0]       hwrite_m,
    input  logic [mst_c-1:0][1:0]  htrans_m,
    input  logic [mst_c-1:0][2:0]  hsize_m,
    input  logic [mst_c-1:0][2:0]  hburst_m,
    output logic [mst_c-1:0][31:0] hrdata_m,
    output logic [mst_c-1:0][1:0]  hresp_m,
    output logic [mst_c-1:0]       hready_m,
    output logic [31:0]            haddr,
    output logic [31:0]            hwdata,
    output logic                   hwrite,
    output logic [1:0]             htrans,
    output logic [2:0]             hsize,
    output logic [2:0]             hburst,
    input  logic [31:0]            hrdata,
    input  logic [1:0]             hresp,
    input  logic                   hready,
    output logic [mst_c-1:0]       grant
);
    localparam int IDX_W = (mst_c > 1) ? $clog2(mst_c) : 1;
    localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(park_m);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;

    typedef enum logic [1:0] {ARB, BURST, BURST_U} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] dph_q, dph_d;
    logic             dph_vld_q, dph_vld_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic [mst_c-1:0] req;
    logic [IDX_W-1:0] pick;
    logic [1:0]       own_trans;
    logic [2:0]       own_burst;
    logic             arb;

    // Remaining beats after the NONSEQ beat: 4-, 8- or 16-beat bursts.
    function automatic logic [3:0] burst_last(input logic [1:0] len_code);
        case (len_code)
            2'b01:   return 4'd3;
            2'b10:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < mst_c; i++) req[i] = (htrans_m[i] == TR_NONSEQ);
    end

    assign own_trans = htrans_m[grant_q];
    assign own_burst = hburst_m[grant_q];

`ifdef AHB_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = PARK_IDX;
        for (int i = mst_c - 1; i >= 0; i--) begin
            if (req[i]) pick = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        pick  = PARK_IDX;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < mst_c; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % mst_c);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_d != grant_q) rr_ptr_d = IDX_W'((int'(grant_d) + 1) % mst_c);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) rr_ptr_q <= IDX_W'((park_m + 1) % mst_c);
        else          rr_ptr_q <= rr_ptr_d;
    end
`endif

    // NOTE: every always_comb target gets a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        dph_d      = dph_q;
        dph_vld_d  = dph_vld_q;
        beat_cnt_d = beat_cnt_q;
        arb        = 1'b0;
        if (hready) begin
            dph_d     = grant_q;
            dph_vld_d = own_trans[1];
            case (state_q)
                BURST: begin
                    if (own_trans == TR_SEQ && beat_cnt_q > 4'd1) begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end else if (own_trans != TR_BUSY) begin
                        beat_cnt_d = '0;
                        arb        = 1'b1;
                    end
                end
                BURST_U: arb = (own_trans == TR_IDLE) || (own_trans == TR_NONSEQ);
                default: arb = 1'b1;
            endcase
            // A boundary edge re-arbitrates immediately, so the owner's new NONSEQ can lock again.
            if (arb) begin
                state_d = ARB;
                if (own_trans == TR_NONSEQ && own_burst != BU_SINGLE) begin
                    if (own_burst == BU_INCR) begin
                        state_d = BURST_U;
                    end else begin
                        state_d    = BURST;
                        beat_cnt_d = burst_last(own_burst[2:1]);
                    end
                end else begin
                    grant_d = pick;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ARB;
            grant_q    <= PARK_IDX;
            dph_q      <= PARK_IDX;
            dph_vld_q  <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            dph_q      <= dph_d;
            dph_vld_q  <= dph_vld_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign haddr    = haddr_m[grant_q];
    assign hwrite   = hwrite_m[grant_q];
    assign htrans   = own_trans;
    assign hsize    = hsize_m[grant_q];
    assign hburst   = own_burst;
    assign hwdata   = hwdata_m[dph_q];
    assign hrdata_m = {mst_c{hrdata}};

    always_comb begin
        hready_m = '1;
        hresp_m  = '0;
        grant    = '0;
        grant[grant_q] = 1'b1;
        for (int i = 0; i < mst_c; i++) begin
            if (IDX_W'(i) == grant_q || (dph_vld_q && IDX_W'(i) == dph_q)) hready_m[i] = hready;
            else if (req[i])                                               hready_m[i] = 1'b0;
            if (dph_vld_q && IDX_W'(i) == dph_q) hresp_m[i] = hresp;
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: expected bus transfers are queued by the stimulus and
// popped by a monitor whenever the shared bus accepts an address phase.
module tb_ahb_arbiter;
    localparam int MST = 3;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;

    typedef struct {
        int          mst;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic                 hclk = 1'b0;
    logic                 hresetn;
    logic [MST-1:0][31:0] haddr_m, hwdata_m, hrdata_m;
    logic [MST-1:0]       hwrite_m, hready_m, grant;
    logic [MST-1:0][1:0]  htrans_m, hresp_m;
    logic [MST-1:0][2:0]  hsize_m, hburst_m;
    logic [31:0]          haddr, hwdata, hrdata;
    logic                 hwrite, hready;
    logic [1:0]           htrans, hresp;
    logic [2:0]           hsize, hburst;

    ahb_arbiter #(.mst_c(MST), .park_m(0)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .haddr_m(haddr_m), .hwdata_m(hwdata_m), .hwrite_m(hwrite_m), .htrans_m(htrans_m),
        .hsize_m(hsize_m), .hburst_m(hburst_m), .hrdata_m(hrdata_m), .hresp_m(hresp_m),
        .hready_m(hready_m), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hrdata(hrdata), .hresp(hresp), .hready(hready),
        .grant(grant)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int m, input logic [1:0] tr, input logic [2:0] bu,
                         input logic wr, input logic [31:0] ad);
        htrans_m[m] = tr;
        hburst_m[m] = bu;
        hwrite_m[m] = wr;
        haddr_m[m]  = ad;
        hsize_m[m]  = 3'b010;
    endtask

    task automatic expect_xfer(input int m, input logic [31:0] ad, input logic [1:0] tr,
                               input logic wr);
        exp_t e;
        e.mst   = m;
        e.addr  = ad;
        e.trans = tr;
        e.write = wr;
        e.wdata = hwdata_m[m];
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
        #1;
    endtask

    // Monitor: checks write data when a data phase completes, then any newly accepted address.
    logic        dph_pend = 1'b0;
    logic [31:0] dph_wdata = '0;
    always @(negedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dph_pend = 1'b0;
        end else if (hclk == 1'b0 && hready) begin
            if (dph_pend) begin
                check("hwdata", hwdata, dph_wdata);
                dph_pend = 1'b0;
            end
            if (htrans[1]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected actual=%0h required=none", haddr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("xfer_grant", grant, 64'(1) << e.mst);
                    check("xfer_haddr", haddr, e.addr);
                    check("xfer_htrans", htrans, e.trans);
                    check("xfer_hwrite", hwrite, e.write);
                    if (e.write) begin
                        dph_pend  = 1'b1;
                        dph_wdata = e.wdata;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn  = 1'b0;
        hready   = 1'b1;
        hresp    = 2'b00;
        hrdata   = '0;
        haddr_m  = '0;
        hwrite_m = '0;
        htrans_m = '0;
        hsize_m  = '0;
        hburst_m = '0;
        hwdata_m[0] = 32'hA0A0_0000;
        hwdata_m[1] = 32'hDEAD_BEEF;
        hwdata_m[2] = 32'hC2C2_0000;

        // Reset state
        mid();
        check("rst_grant", grant, 3'b001);
        check("rst_htrans", htrans, IDLE);
        check("rst_hready_m", hready_m, 3'b111);
        check("rst_hresp_m", hresp_m, '0);

        // Master 1 single write while parked on master 0
        step();
        hresetn = 1'b1;
        drive(1, NONSEQ, SINGLE, 1'b1, 32'h0001_0004);
        expect_xfer(1, 32'h0001_0004, NONSEQ, 1'b1);
        mid();
        check("s1_stall_m1", hready_m[1], 1'b0);
        check("s1_ready_m0", hready_m[0], 1'b1);
        check("s1_grant0", grant, 3'b001);
        step();
        mid();
        check("s1_grant1", grant, 3'b010);
        check("s1_ready_m1", hready_m[1], 1'b1);
        check("s1_ready_m0b", hready_m[0], 1'b1);
        step();
        drive(1, IDLE, SINGLE, 1'b0, '0);
        mid();
        check("s1_ready_m0c", hready_m[0], 1'b1);
        step();
        mid();
        check("s1_park", grant, 3'b001);

        // Continuous single writes from masters 0 and 1
        step();
        drive(0, NONSEQ, SINGLE, 1'b1, 32'h0000_0100);
        drive(1, NONSEQ, SINGLE, 1'b1, 32'h0000_0200);
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) expect_xfer(0, 32'h0000_0100, NONSEQ, 1'b1);
`else
        for (int i = 0; i < 2; i++) begin
            expect_xfer(0, 32'h0000_0100, NONSEQ, 1'b1);
            expect_xfer(1, 32'h0000_0200, NONSEQ, 1'b1);
        end
`endif
        mid();
        check("s2_stall_m1", hready_m[1], 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            mid();
        end
        step();
        drive(0, IDLE, SINGLE, 1'b0, '0);
        drive(1, IDLE, SINGLE, 1'b0, '0);
        mid();

        // Master 0 INCR4 held against a waiting master 1
        step();
        drive(0, NONSEQ, INCR4, 1'b1, 32'h0002_0000);
        drive(1, NONSEQ, SINGLE, 1'b1, 32'h0000_0300);
        expect_xfer(0, 32'h0002_0000, NONSEQ, 1'b1);
        mid();
        check("s3_stall_m1", hready_m[1], 1'b0);
        for (int b = 1; b < 4; b++) begin
            step();
            drive(0, SEQ, INCR4, 1'b1, 32'h0002_0000 + 32'(4 * b));
            expect_xfer(0, 32'h0002_0000 + 32'(4 * b), SEQ, 1'b1);
            mid();
            check("s3_burst_hold", grant, 3'b001);
            check("s3_burst_stall", hready_m[1], 1'b0);
        end
        step();
        drive(0, IDLE, SINGLE, 1'b0, '0);
        expect_xfer(1, 32'h0000_0300, NONSEQ, 1'b1);
        mid();
        check("s3_regrant", grant, 3'b010);
        step();
        drive(1, IDLE, SINGLE, 1'b0, '0);
        mid();

        // INCR4 with three wait states on beat 2's data phase
        step();
        drive(0, NONSEQ, INCR4, 1'b1, 32'h0002_0010);
        drive(1, NONSEQ, SINGLE, 1'b1, 32'h0000_0304);
        expect_xfer(0, 32'h0002_0010, NONSEQ, 1'b1);
        mid();
        step();
        drive(0, SEQ, INCR4, 1'b1, 32'h0002_0014);
        expect_xfer(0, 32'h0002_0014, SEQ, 1'b1);
        mid();
        step();
        drive(0, SEQ, INCR4, 1'b1, 32'h0002_0018);
        expect_xfer(0, 32'h0002_0018, SEQ, 1'b1);
        hready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w != 0) step();
            mid();
            check("s4_wait_grant", grant, 3'b001);
            check("s4_wait_hwdata", hwdata, 32'hA0A0_0000);
            check("s4_wait_ready_m0", hready_m[0], 1'b0);
        end
        step();
        hready = 1'b1;
        mid();
        step();
        drive(0, SEQ, INCR4, 1'b1, 32'h0002_001C);
        expect_xfer(0, 32'h0002_001C, SEQ, 1'b1);
        mid();
        check("s4_beat4_grant", grant, 3'b001);
        step();
        drive(0, IDLE, SINGLE, 1'b0, '0);
        expect_xfer(1, 32'h0000_0304, NONSEQ, 1'b1);
        mid();
        check("s4_regrant", grant, 3'b010);
        step();
        drive(1, IDLE, SINGLE, 1'b0, '0);
        mid();

        // ERROR on beat 2 of master 1's INCR8, master 0 waiting
        step();
        drive(1, NONSEQ, INCR8, 1'b1, 32'h0001_0100);
        mid();
        check("s5_grant0", grant, 3'b001);
        step();
        expect_xfer(1, 32'h0001_0100, NONSEQ, 1'b1);
        drive(0, NONSEQ, SINGLE, 1'b0, 32'h0000_0400);
        mid();
        check("s5_grant1", grant, 3'b010);
        step();
        drive(1, SEQ, INCR8, 1'b1, 32'h0001_0104);
        expect_xfer(1, 32'h0001_0104, SEQ, 1'b1);
        mid();
        step();
        drive(1, IDLE, SINGLE, 1'b0, '0);
        hready = 1'b0;
        hresp  = 2'b01;
        mid();
        check("s5_err1_m1", hresp_m[1], 2'b01);
        check("s5_err1_m0", hresp_m[0], 2'b00);
        check("s5_err1_stall_m0", hready_m[0], 1'b0);
        step();
        hready = 1'b1;
        mid();
        check("s5_err2_m1", hresp_m[1], 2'b01);
        check("s5_err2_m0", hresp_m[0], 2'b00);
        check("s5_err2_ready_m1", hready_m[1], 1'b1);
        step();
        hresp = 2'b00;
        expect_xfer(0, 32'h0000_0400, NONSEQ, 1'b0);
        mid();
        check("s5_regrant", grant, 3'b001);
        step();
        drive(0, IDLE, SINGLE, 1'b0, '0);
        hrdata = 32'h1234_5678;
        mid();
        check("s5_hrdata_m0", hrdata_m[0], 32'h1234_5678);
        check("s5_hrdata_m2", hrdata_m[2], 32'h1234_5678);

        // Reset mid-burst
        step();
        drive(1, NONSEQ, INCR4, 1'b1, 32'h0001_0200);
        mid();
        step();
        expect_xfer(1, 32'h0001_0200, NONSEQ, 1'b1);
        mid();
        step();
        drive(1, SEQ, INCR4, 1'b1, 32'h0001_0204);
        drive(0, NONSEQ, SINGLE, 1'b1, 32'h0000_0600);
        expect_xfer(1, 32'h0001_0204, SEQ, 1'b1);
        mid();
        check("s6_grant1", grant, 3'b010);
        #2;
        hresetn = 1'b0;
        #1;
        check("s6_rst_grant", grant, 3'b001);
        check("s6_rst_htrans", htrans, NONSEQ);
        check("s6_rst_haddr", haddr, 32'h0000_0600);
        drive(0, IDLE, SINGLE, 1'b0, '0);
        drive(1, IDLE, SINGLE, 1'b0, '0);
        step();
        hresetn = 1'b1;
        drive(1, NONSEQ, SINGLE, 1'b0, 32'h0001_0300);
        mid();
        check("s6_post_grant0", grant, 3'b001);
        step();
        expect_xfer(1, 32'h0001_0300, NONSEQ, 1'b0);
        mid();
        check("s6_post_grant1", grant, 3'b010);
        step();
        drive(1, IDLE, SINGLE, 1'b0, '0);
        mid();

        // Concurrent requests from masters 0 and 2 after master 1 held the bus
        step();
        drive(1, NONSEQ, SINGLE, 1'b1, 32'h0000_0700);
        mid();
        step();
        expect_xfer(1, 32'h0000_0700, NONSEQ, 1'b1);
        drive(0, NONSEQ, SINGLE, 1'b1, 32'h0000_0800);
        drive(2, NONSEQ, SINGLE, 1'b1, 32'h0000_0900);
        mid();
        check("s7_grant1", grant, 3'b010);
        step();
        drive(1, IDLE, SINGLE, 1'b0, '0);
`ifdef AHB_ARB_FIXED_PRIO_EN
        expect_xfer(0, 32'h0000_0800, NONSEQ, 1'b1);
        mid();
        check("s7_prio_first", grant, 3'b001);
        step();
        drive(0, IDLE, SINGLE, 1'b0, '0);
        mid();
        step();
        expect_xfer(2, 32'h0000_0900, NONSEQ, 1'b1);
        mid();
        check("s7_prio_second", grant, 3'b100);
`else
        expect_xfer(2, 32'h0000_0900, NONSEQ, 1'b1);
        mid();
        check("s7_rr_first", grant, 3'b100);
        step();
        expect_xfer(0, 32'h0000_0800, NONSEQ, 1'b1);
        drive(2, IDLE, SINGLE, 1'b0, '0);
        mid();
        check("s7_rr_second", grant, 3'b001);
        step();
        drive(0, IDLE, SINGLE, 1'b0, '0);
        mid();
`endif
        step();
        drive(0, IDLE, SINGLE, 1'b0, '0);
        drive(2, IDLE, SINGLE, 1'b0, '0);
        mid();
        step();
        mid();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
AHB-lite multi-master arbiter. It shares one AHB master port, normally the master side of ahb_router, between mst_c requesting masters.
- Round-robin grant, switched only on transfer/burst boundaries.
- Losing masters are held off by driving their hready low.
- Tracks the data-phase owner so that hwdata, hrdata, hresp and hready route to the correct master.

Parameters:
mst_c, 2, number of masters (2..8)
park_m, 0, master index granted after reset and while no master requests

Ports:
hclk  in  1  ahb clock
hresetn  in  1  ahb reset, asynchronous, active-low
haddr_m  in  [mst_c][32]  master addresses
hwdata_m  in  [mst_c][32]  master write data
hwrite_m  in  [mst_c][1]  master write
htrans_m  in  [mst_c][2]  master transfer type
hsize_m  in  [mst_c][3]  master size
hburst_m  in  [mst_c][3]  master burst
hrdata_m  out  [mst_c][32]  read data (broadcast of hrdata)
hresp_m  out  [mst_c][2]  per-master response
hready_m  out  [mst_c][1]  per-master ready
haddr  out  32  shared bus address
hwdata  out  32  shared write data
hwrite  out  1  shared write
htrans  out  2  shared transfer type
hsize  out  3  shared size
hburst  out  3  shared burst
hrdata  in  32  read data from router
hresp  in  2  response from router
hready  in  1  ready from router
grant  out  [mst_c]  one-hot address-phase owner (debug/perf)

Behaviour:
- Reset, async on hresetn=0:
  - grant_q = park_m; dph_q = park_m; dph_vld = 0.
  - beat_cnt = 0; rr_ptr = park_m+1 mod mst_c; state = ARB.
- Address mux: haddr/hwrite/htrans/hsize/hburst = fields of master grant_q, combinational. Zero latency when the requester is already granted.
- Request: master i requests when htrans_m[i] == NONSEQ.
- States:
  - ARB: bus free.
    - At a posedge with hready=1: if grant_q requests NONSEQ with hburst ≠ SINGLE/INCR, load beat_cnt = beats−1 (INCR4/WRAP4=3, 8-beat=7, 16-beat=15) and go BURST.
    - If hburst = INCR, go BURST_U.
    - Else, if grant_q is not requesting, pick the next requester in round-robin order from rr_ptr. If there is none, park on park_m.
  - BURST: at each hready=1 edge with owner htrans=SEQ, beat_cnt−1. When beat_cnt reaches 0, or owner drives IDLE (early termination, e.g. after ERROR), go ARB and allow regrant that edge. BUSY holds the count.
  - BURST_U: hold grant while owner drives SEQ/BUSY. Owner IDLE or NONSEQ means a boundary: go ARB.
- Grant change: only at posedge with hready=1. On change, rr_ptr = new grant+1 mod mst_c.
- Data phase: at posedge with hready=1, dph_q = grant_q and dph_vld = htrans[1]. hwdata = hwdata_m[dph_q].
- Per-master ready/response:
  - hready_m[i] = hready if i == grant_q or (dph_vld and i == dph_q).
  - Else hready_m[i] = 0 if master i requests NONSEQ and is not granted (stall; the master holds its address).
  - Else hready_m[i] = 1.
  - hresp_m[i] = hresp when dph_vld and i == dph_q, else OKAY(0).
- hready=0: grant, beat_cnt, dph_q and rr_ptr all frozen.
- Reset mid-burst: immediate return to reset values; htrans then reflects park_m's htrans.

Optional Feature:
AHB_ARB_FIXED_PRIO_EN
- Defined: ARB picks the lowest-index requester (master 0 highest priority). rr_ptr is not implemented. Burst locking is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset with park_m=0; master 1 NONSEQ SINGLE write 0x0001_0004 / 0xDEADBEEF → hready_m[1]=0 for 1 cycle, grant=0b10 next edge, router slave 1 sees write of 0xDEADBEEF, hready_m[0]=1 throughout.
- Masters 0 and 1 both issue continuous SINGLE writes → grants alternate 0,1,0,1; no master is starved more than 1 transfer.
- Master 0 INCR4 at 0x0002_0000 while master 1 requests → 4 beats with grant=0b01 uninterrupted, master 1 granted on the edge completing beat 4.
- Slave inserts 3 wait states (hready=0) mid-INCR4 → grant and beat_cnt frozen, hwdata stays master 0 data, burst completes with 4 beats.
- hresp=ERROR on beat 2 of master 1's INCR8, master 1 drives IDLE → hresp_m[1]=ERROR, hresp_m[0]=OKAY, arbiter returns to ARB and grants the waiting master 0.
- hresetn asserted mid-burst → grant=park_m and htrans out follows park_m immediately. With AHB_ARB_FIXED_PRIO_EN, concurrent requests from 0 and 2 always grant 0 first.
